// File: rtl/ldl_fifo_ws_pkt.sv
// LDL synchronous FIFO write-side pointer controller.
// Tracks a shadow write pointer and publishes a committed pointer to the reader.
module ldl_fifo_ws_pkt #(
    parameter int AW       = 8,
    parameter int AFULL_TH = 2**AW - 4,
    parameter int PKT_MODE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          commit,
    input  logic          drop,
    input  logic          ovf_clr,
    input  logic [AW:0]   r_pt,
    output logic [AW:0]   w_pt,
    output logic [AW-1:0] wa,
    output logic          ram_we,
    output logic          full,
    output logic          afull,
    output logic [AW:0]   wcnt,
    output logic          stall,
    output logic          ovf
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] TH    = (AW+1)'(AFULL_TH);

    logic [AW:0] s_pt;
    logic [AW:0] s_inc;
    logic [AW:0] s_pt_nxt;
    logic [AW:0] w_pt_nxt;
    logic [AW:0] occ_nxt;
    logic        fw;
    logic        full_nxt;
    logic        afull_nxt;
    logic        stall_nxt;

    always_comb begin
        fw       = we & ~full;
        s_inc    = s_pt + {{AW{1'b0}}, fw};
        s_pt_nxt = s_inc;
        w_pt_nxt = s_inc;
        if (PKT_MODE != 0) begin
            w_pt_nxt = w_pt;
            // Drop rewinds to the last published point and beats commit.
            if (drop) begin
                s_pt_nxt = w_pt;
            end else if (commit) begin
                w_pt_nxt = s_inc;
            end
        end
        occ_nxt   = s_pt_nxt - r_pt;
        full_nxt  = (occ_nxt == DEPTH);
        afull_nxt = (occ_nxt >= TH);
        stall_nxt = (PKT_MODE != 0) && full_nxt && (w_pt_nxt == r_pt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_pt  <= '0;
            w_pt  <= '0;
            full  <= 1'b0;
            afull <= 1'b0;
            stall <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            s_pt  <= s_pt_nxt;
            w_pt  <= w_pt_nxt;
            full  <= full_nxt;
            afull <= afull_nxt;
            stall <= stall_nxt;
            if (we && full) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign wa     = s_pt[AW-1:0];
    assign ram_we = fw;
    assign wcnt   = s_pt - r_pt;

endmodule

// File: tb/tb_ldl_fifo_ws_pkt.sv
// Bench for ldl_fifo_ws_pkt: streaming (index 0) and packet (index 1) instances
// driven together and compared against an occupancy-count model.
module tb_ldl_fifo_ws_pkt;

    logic clk = 1'b0;
    logic rst;
    logic we, commit, drop, ovf_clr;
    logic [1:0][2:0] rpt;
    logic [1:0][2:0] wpt;
    logic [1:0][1:0] wa_o;
    logic [1:0][2:0] wcnt_o;
    logic [1:0] ramwe_o, full_o, afull_o, stall_o, ovf_o;

    int errors = 0;
    int checks = 0;

    // Model: unbounded word counts; pointers are these counts mod 8.
    int wr[2];
    int cm[2];
    int rd[2];
    bit mfull[2], mafull[2], mstall[2], movf[2];

    always #5 clk = ~clk;

    ldl_fifo_ws_pkt #(.AW(2), .AFULL_TH(3), .PKT_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .commit(commit), .drop(drop),
        .ovf_clr(ovf_clr), .r_pt(rpt[0]), .w_pt(wpt[0]), .wa(wa_o[0]),
        .ram_we(ramwe_o[0]), .full(full_o[0]), .afull(afull_o[0]),
        .wcnt(wcnt_o[0]), .stall(stall_o[0]), .ovf(ovf_o[0])
    );

    ldl_fifo_ws_pkt #(.AW(2), .AFULL_TH(3), .PKT_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .commit(commit), .drop(drop),
        .ovf_clr(ovf_clr), .r_pt(rpt[1]), .w_pt(wpt[1]), .wa(wa_o[1]),
        .ram_we(ramwe_o[1]), .full(full_o[1]), .afull(afull_o[1]),
        .wcnt(wcnt_o[1]), .stall(stall_o[1]), .ovf(ovf_o[1])
    );

    task automatic chk(input string tag, input int k,
                       input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            wr[k] = 0; cm[k] = 0; rd[k] = 0;
            mfull[k] = 0; mafull[k] = 0; mstall[k] = 0; movf[k] = 0;
        end
    endtask

    task automatic mstep(input int k, input bit w, input bit c,
                         input bit d, input bit clr);
        bit pk;
        bit fw;
        int occ;
        pk = (k == 1);
        fw = w && !mfull[k];
        if (w && mfull[k]) movf[k] = 1;
        else if (clr) movf[k] = 0;
        if (pk && d) begin
            wr[k] = cm[k];
        end else begin
            wr[k] = wr[k] + int'(fw);
            if (!pk || c) cm[k] = wr[k];
        end
        occ = wr[k] - rd[k];
        mfull[k]  = (occ == 4);
        mafull[k] = (occ >= 3);
        mstall[k] = pk && mfull[k] && (cm[k] == rd[k]);
    endtask

    task automatic chk_reg();
        for (int k = 0; k < 2; k++) begin
            chk("w_pt", k, 8'(wpt[k]), 8'(cm[k] % 8));
            chk("full", k, 8'(full_o[k]), 8'(mfull[k]));
            chk("afull", k, 8'(afull_o[k]), 8'(mafull[k]));
            chk("stall", k, 8'(stall_o[k]), 8'(mstall[k]));
            chk("ovf", k, 8'(ovf_o[k]), 8'(movf[k]));
            chk("wcnt", k, 8'(wcnt_o[k]), 8'((wr[k] - rd[k]) % 8));
        end
    endtask

    // One clock: optional reads, drive inputs, check comb, edge, check regs.
    task automatic cyc(input bit w, input bit c, input bit d, input bit clr,
                       input bit r0, input bit r1);
        bit rq[2];
        rq[0] = r0; rq[1] = r1;
        for (int k = 0; k < 2; k++) begin
            if (rq[k] && cm[k] > rd[k]) rd[k]++;
            rpt[k] = 3'(rd[k] % 8);
        end
        we = w; commit = c; drop = d; ovf_clr = clr;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("ram_we", k, 8'(ramwe_o[k]), 8'(w && !mfull[k]));
            chk("wa", k, 8'(wa_o[k]), 8'(wr[k] % 4));
            chk("wcnt_c", k, 8'(wcnt_o[k]), 8'((wr[k] - rd[k]) % 8));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) mstep(k, w, c, d, clr);
        #1;
        chk_reg();
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        we = 0; commit = 0; drop = 0; ovf_clr = 0;
        rpt = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reg();
    endtask

    initial begin
        rst = 1'b0;
        we = 0; commit = 0; drop = 0; ovf_clr = 0;
        rpt = '0;
        model_reset();
        #2;
        sync_reset();

        // Fill both with 4 writes, no commits.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk("fill_wpt", 0, 8'(wpt[0]), 8'(i + 1));
        end
        chk("fill_full", 0, 8'(full_o[0]), 8'd1);
        chk("fill_stall", 1, 8'(stall_o[1]), 8'd1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("ovf_set", 0, 8'(ovf_o[0]), 8'd1);
        chk("ovf_spt", 0, 8'(wcnt_o[0]), 8'd4);
        cyc(0, 0, 1, 0, 0, 0);
        chk("drop_wcnt", 1, 8'(wcnt_o[1]), 8'd0);
        chk("drop_stall", 1, 8'(stall_o[1]), 8'd0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("ovf_clr", 1, 8'(ovf_o[1]), 8'd0);
        cyc(1, 1, 0, 1, 0, 0);
        chk("ovf_setwins", 0, 8'(ovf_o[0]), 8'd1);
        cyc(1, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-packet, checked before the next edge.
        #1 rst = 1'b1;
        rpt = '0;
        #1;
        model_reset();
        chk_reg();
        for (int k = 0; k < 2; k++) chk("rst_wa", k, 8'(wa_o[k]), 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Three words, commit on the third; then a dropped fourth.
        cyc(1, 0, 0, 0, 0, 0);
        chk("pkt_wpt0", 1, 8'(wpt[1]), 8'd0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("pkt_wpt1", 1, 8'(wpt[1]), 8'd0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("pkt_wpt2", 1, 8'(wpt[1]), 8'd3);
        cyc(1, 0, 1, 0, 0, 0);
        chk("pkt_drop_wcnt", 1, 8'(wcnt_o[1]), 8'd3);
        chk("pkt_drop_wpt", 1, 8'(wpt[1]), 8'd3);
        cyc(0, 1, 0, 0, 0, 0);

        // Commit and drop together with a write: drop wins.
        sync_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("cd_wcnt", 1, 8'(wcnt_o[1]), 8'd0);
        chk("cd_wpt", 1, 8'(wpt[1]), 8'd0);

        // Almost-full, then steady write+read across pointer wrap.
        sync_reset();
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
        chk("afull_on", 0, 8'(afull_o[0]), 8'd1);
        cyc(0, 0, 0, 0, 1, 1);
        chk("afull_off", 0, 8'(afull_o[0]), 8'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 0, 1, 1);
            chk("wrap_full", 0, 8'(full_o[0]), 8'd0);
            chk("wrap_wcnt", 0, 8'(wcnt_o[0]), 8'd2);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
